// File: rtl/base64_decoder.sv
// Streaming Base64 decoder: ASCII characters in, decoded bytes out, with '=' pad handling.
// Optional build macro BASE64_SKIP_WS_EN makes CR, LF, space and TAB silently ignored.
module base64_decoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       msg_done,
   output logic       err
);

   // state   | meaning
   // COLLECT | accepting characters, building a quartet in s0..s3
   // EMIT    | presenting the first n decoded bytes, input stalled

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [1:0] pos, pos_nxt;
   logic [5:0] s0, s1, s2, s3;
   logic [5:0] s0_nxt, s1_nxt, s2_nxt, s3_nxt;
   logic       pad2, pad2_nxt;
   logic [1:0] n, n_nxt;
   logic [1:0] idx, idx_nxt;
   logic       in_ready_nxt, out_valid_nxt, msg_done_nxt, err_nxt;
   logic [7:0] out_data_nxt;

   logic [5:0] sextet;
   logic       is_b64, is_pad, bad, accept;
   logic [7:0] byte1, byte2;

`ifdef BASE64_SKIP_WS_EN
   logic is_ws;
   assign is_ws = (in_data == 8'h0D) || (in_data == 8'h0A) ||
                  (in_data == 8'h20) || (in_data == 8'h09);
`else
   logic is_ws;
   assign is_ws = 1'b0;
`endif

   always_comb begin
      sextet = 6'd0;
      is_b64 = 1'b0;
      is_pad = (in_data == 8'h3D);
      if (in_data >= 8'h41 && in_data <= 8'h5A) begin
         is_b64 = 1'b1;
         sextet = 6'(in_data - 8'd65);
      end else if (in_data >= 8'h61 && in_data <= 8'h7A) begin
         is_b64 = 1'b1;
         sextet = 6'(in_data - 8'd71);
      end else if (in_data >= 8'h30 && in_data <= 8'h39) begin
         is_b64 = 1'b1;
         sextet = 6'(in_data + 8'd4);
      end else if (in_data == 8'h2B) begin
         is_b64 = 1'b1;
         sextet = 6'd62;
      end else if (in_data == 8'h2F) begin
         is_b64 = 1'b1;
         sextet = 6'd63;
      end
   end

   // A pad is only legal in the last two slots, and once slot 2 is a pad slot 3 must be too.
   assign bad = (!is_b64 && !is_pad) ||
                (is_pad && (pos < 2'd2)) ||
                (!is_pad && (pos == 2'd3) && pad2);

   assign accept = in_valid && in_ready;
   assign byte1  = {s1[3:0], s2[5:2]};
   assign byte2  = {s2[1:0], s3};

   always_comb begin
      state_nxt     = state;
      pos_nxt       = pos;
      s0_nxt        = s0;
      s1_nxt        = s1;
      s2_nxt        = s2;
      s3_nxt        = s3;
      pad2_nxt      = pad2;
      n_nxt         = n;
      idx_nxt       = idx;
      in_ready_nxt  = in_ready;
      out_data_nxt  = out_data;
      out_valid_nxt = out_valid;
      msg_done_nxt  = 1'b0;
      err_nxt       = 1'b0;
      case (state)
         COLLECT: begin
            in_ready_nxt = 1'b1;
            if (accept && !is_ws) begin
               if (bad) begin
                  pos_nxt  = 2'd0;
                  pad2_nxt = 1'b0;
                  err_nxt  = 1'b1;
               end else begin
                  case (pos)
                     2'd0: s0_nxt = sextet;
                     2'd1: s1_nxt = sextet;
                     2'd2: begin
                        s2_nxt   = sextet;
                        pad2_nxt = is_pad;
                     end
                     default: s3_nxt = sextet;
                  endcase
                  pos_nxt = 2'(pos + 2'd1);
                  if (pos == 2'd3) begin
                     // byte0 only needs s0/s1, which are already held
                     state_nxt     = EMIT;
                     pos_nxt       = 2'd0;
                     pad2_nxt      = 1'b0;
                     idx_nxt       = 2'd0;
                     in_ready_nxt  = 1'b0;
                     out_valid_nxt = 1'b1;
                     out_data_nxt  = {s0, s1[5:4]};
                     n_nxt         = !is_pad ? 2'd3 : (pad2 ? 2'd1 : 2'd2);
                  end
               end
            end
         end
         EMIT: begin
            in_ready_nxt = 1'b0;
            if (out_ready) begin
               if (idx == 2'(n - 2'd1)) begin
                  state_nxt     = COLLECT;
                  idx_nxt       = 2'd0;
                  out_valid_nxt = 1'b0;
                  in_ready_nxt  = 1'b1;
                  msg_done_nxt  = (n != 2'd3);
               end else begin
                  idx_nxt      = 2'(idx + 2'd1);
                  out_data_nxt = (idx == 2'd0) ? byte1 : byte2;
               end
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         pos       <= 2'd0;
         s0        <= 6'd0;
         s1        <= 6'd0;
         s2        <= 6'd0;
         s3        <= 6'd0;
         pad2      <= 1'b0;
         n         <= 2'd3;
         idx       <= 2'd0;
         in_ready  <= 1'b0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         msg_done  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         pos       <= pos_nxt;
         s0        <= s0_nxt;
         s1        <= s1_nxt;
         s2        <= s2_nxt;
         s3        <= s3_nxt;
         pad2      <= pad2_nxt;
         n         <= n_nxt;
         idx       <= idx_nxt;
         in_ready  <= in_ready_nxt;
         out_data  <= out_data_nxt;
         out_valid <= out_valid_nxt;
         msg_done  <= msg_done_nxt;
         err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_base64_decoder.sv
// Self-checking bench for base64_decoder: quartet-level reference model plus directed vectors.
module tb_base64_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, msg_done, err;
   logic [7:0] out_data;

   base64_decoder dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .msg_done(msg_done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   byte        quad[$];
   logic [8:0] exp_q[$];   // {msg_done after this byte, byte}
   logic [7:0] got[$];
   int         n_err = 0, n_done = 0;

   function automatic int b64_val(input byte c);
      string alpha;
      alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
      for (int i = 0; i < 64; i++) if (alpha[i] == c) return i;
      return -1;
   endfunction

   function automatic logic [23:0] decode4(input byte c0, input byte c1, input byte c2, input byte c3);
      byte c[4];
      logic [23:0] w;
      c = '{c0, c1, c2, c3};
      w = 24'd0;
      for (int i = 0; i < 4; i++) w = (w << 6) | 24'((c[i] == "=") ? 0 : b64_val(c[i]));
      return w;
   endfunction

   // Returns 1 when the accepted character must raise err.
   function automatic bit model_accept(input byte c);
      int np;
      logic [23:0] w;
`ifdef BASE64_SKIP_WS_EN
      if (c == 8'h0D || c == 8'h0A || c == 8'h20 || c == 8'h09) return 1'b0;
`endif
      if (c == "=") begin
         if (quad.size() < 2) begin quad.delete(); return 1'b1; end
      end else if (b64_val(c) < 0 || (quad.size() == 3 && quad[2] == "=")) begin
         quad.delete();
         return 1'b1;
      end
      quad.push_back(c);
      if (quad.size() == 4) begin
         w  = decode4(quad[0], quad[1], quad[2], quad[3]);
         np = int'(quad[2] == "=") + int'(quad[3] == "=");
         for (int i = 0; i < 3 - np; i++)
            exp_q.push_back({(np > 0 && i == 2 - np), w[23 - 8*i -: 8]});
         quad.delete();
      end
      return 1'b0;
   endfunction

   // ---------------- compare process ----------------
   logic       done_next = 1'b0, err_next = 1'b0, stall_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;
   logic [8:0] e;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_msg_done", msg_done, 0);
         chk("rst_err", err, 0);
         quad.delete();
         exp_q.delete();
         done_next  = 1'b0;
         err_next   = 1'b0;
         stall_prev = 1'b0;
      end else begin
         chk("msg_done", msg_done, done_next);
         chk("err", err, err_next);
         chk("ready_valid_overlap", in_ready & out_valid, 0);
         if (msg_done) n_done++;
         if (err) n_err++;
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, data_prev);
         end
         stall_prev = out_valid && !out_ready;
         data_prev  = out_data;
         done_next  = 1'b0;
         err_next   = 1'b0;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e[7:0]);
               done_next = e[8];
            end
         end
         if (in_valid && in_ready) err_next = model_accept(byte'(in_data));
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input string s);
      int t;
      for (int i = 0; i < s.len(); i++) begin
         t = 0;
         in_data  = s[i];
         in_valid = 1'b1;
         @(negedge clk);
         while (!in_ready && t < 200) begin @(negedge clk); t++; end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0, expected 1");
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((out_valid || !in_ready || exp_q.size() != 0) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 500) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: decoder busy, expected idle");
      end
      @(posedge clk); #1;
   endtask

   task automatic check_got(input string name, input int cnt, input logic [23:0] v);
      chk({name, "_count"}, got.size(), cnt);
      for (int i = 0; i < cnt && i < got.size(); i++) chk(name, got[i], v[23 - 8*i -: 8]);
      got.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 0);
      chk("async_rst_out_data", out_data, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", in_ready, 1);
   endtask

   int e0, d0;

   initial begin
      chk("model_TWFu", decode4("T", "W", "F", "u"), 24'h4D616E);
      chk("model_TWE=", decode4("T", "W", "E", "="), 24'h4D6100);
      chk("model_TQ==", decode4("T", "Q", "=", "="), 24'h4D0000);
      #2 rst_n = 1'b0;
      do_reset();
      out_ready = 1'b1;

      // basic quartet with cycle-exact output timing
      d0 = n_done;
      send("TWFu");
      chk("t1_valid0", out_valid, 1);
      chk("t1_byte0", out_data, 8'h4D);
      chk("t1_in_ready0", in_ready, 0);
      @(posedge clk); #1;
      chk("t1_byte1", out_data, 8'h61);
      @(posedge clk); #1;
      chk("t1_byte2", out_data, 8'h6E);
      @(posedge clk); #1;
      chk("t1_valid_end", out_valid, 0);
      chk("t1_in_ready_end", in_ready, 1);
      wait_idle();
      check_got("t1", 3, 24'h4D616E);
      chk("t1_no_done", n_done - d0, 0);

      // padded quartets
      d0 = n_done;
      send("TWE=");
      wait_idle();
      check_got("t2a", 2, 24'h4D6100);
      chk("t2a_done", n_done - d0, 1);
      send("TQ==");
      wait_idle();
      check_got("t2b", 1, 24'h4D0000);
      chk("t2b_done", n_done - d0, 2);

      // invalid character mid-quartet; 'u' starts a fresh quartet "uTWF"
      e0 = n_err;
      send("TW*u");
      send("TWFu");
      wait_idle();
      chk("t3a_err", n_err - e0, 1);
      check_got("t3a", 3, 24'hB93585);
      send("=");
      wait_idle();
      chk("t3a_resync_err", n_err - e0, 2);
      got.delete();
      e0 = n_err;
      send("TW*");
      send("TWFu");
      wait_idle();
      chk("t3b_err", n_err - e0, 1);
      check_got("t3b", 3, 24'h4D616E);

      // illegal pad positions
      e0 = n_err;
      send("=AAA*");
      wait_idle();
      chk("t3c_err", n_err - e0, 2);
      check_got("t3c", 0, 24'h0);
      e0 = n_err;
      send("AB=C");
      wait_idle();
      chk("t3d_err", n_err - e0, 1);
      check_got("t3d", 0, 24'h0);

      // backpressure
      out_ready = 1'b0;
      send("TWFu");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t4_valid", out_valid, 1);
         chk("t4_data", out_data, 8'h4D);
         chk("t4_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      wait_idle();
      check_got("t4", 3, 24'h4D616E);

      // reset after the first output byte
      d0 = n_done;
      e0 = n_err;
      send("TWFu");
      do_reset();
      check_got("t5_pre", 1, 24'h4D0000);
      send("TWFu");
      wait_idle();
      check_got("t5", 3, 24'h4D616E);
      chk("t5_no_done", n_done - d0, 0);
      chk("t5_no_err", n_err - e0, 0);

      // whitespace inside a quartet
      e0 = n_err;
      send("TW\015\012Fu");
      wait_idle();
`ifdef BASE64_SKIP_WS_EN
      chk("t6_err", n_err - e0, 0);
      check_got("t6", 3, 24'h4D616E);
`else
      chk("t6_err", n_err - e0, 2);
      check_got("t6", 0, 24'h0);
      send("*");
      wait_idle();
`endif

      chk("exp_q_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
